// File: rtl/decode_pkg.sv
// decode_pkg: shared RV32I constants, ALU operation encoding, the decoded
// instruction bundle and the decode-stage FSM state type.
package decode_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned ALU_OP_W   = 4;
  localparam int unsigned FUNCT3_W   = 3;

  // RV32I major opcodes, also used by fetch
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_FULL      = 2'd1,
    ST_SKID_FULL = 2'd2
  } state_e;

  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_write;
    logic [PC_W-1:0]       imm;
    alu_op_e               alu_op;
    logic                  alu_src_a_pc;
    logic                  alu_src_b_imm;
    logic                  mem_read;
    logic                  mem_write;
    logic [FUNCT3_W-1:0]   mem_funct3;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  bp_taken;
    logic                  illegal;
  } decoded_t;

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch->decode input handshake plus decode->execute output bundle.
// slave = decode stage, master = the driver/observer of the stage.
interface decode_if
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
);

  logic                  valid_in;
  logic [INSTR_W-1:0]    instr_in;
  logic [XLEN-1:0]       pc_in;
  logic                  branch_predicted_taken_in;
  logic                  ready_out;
  logic                  flush_in;
  logic                  stall_in;

  logic                  valid_out;
  logic [XLEN-1:0]       pc_out;
  logic [REG_ADDR_W-1:0] rs1_addr_out;
  logic [REG_ADDR_W-1:0] rs2_addr_out;
  logic [REG_ADDR_W-1:0] rd_addr_out;
  logic                  rd_write_out;
  logic [XLEN-1:0]       imm_out;
  logic [ALU_OP_W-1:0]   alu_op_out;
  logic                  alu_src_a_pc_out;
  logic                  alu_src_b_imm_out;
  logic                  mem_read_out;
  logic                  mem_write_out;
  logic [FUNCT3_W-1:0]   mem_funct3_out;
  logic                  branch_out;
  logic                  jal_out;
  logic                  jalr_out;
  logic                  branch_predicted_taken_out;
  logic                  illegal_instr_out;

  modport slave (
    input  valid_in, instr_in, pc_in, branch_predicted_taken_in, flush_in, stall_in,
    output ready_out, valid_out, pc_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
           rd_write_out, imm_out, alu_op_out, alu_src_a_pc_out, alu_src_b_imm_out,
           mem_read_out, mem_write_out, mem_funct3_out, branch_out, jal_out, jalr_out,
           branch_predicted_taken_out, illegal_instr_out
  );

  modport master (
    output valid_in, instr_in, pc_in, branch_predicted_taken_in, flush_in, stall_in,
    input  ready_out, valid_out, pc_out, rs1_addr_out, rs2_addr_out, rd_addr_out,
           rd_write_out, imm_out, alu_op_out, alu_src_a_pc_out, alu_src_b_imm_out,
           mem_read_out, mem_write_out, mem_funct3_out, branch_out, jal_out, jalr_out,
           branch_predicted_taken_out, illegal_instr_out
  );

endinterface

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I decoder.
// Ports: instr_i/pc_i/bp_taken_i in; dec_o = decoded bundle including
// immediate, ALU/memory/control-flow controls and the illegal flag.
module decode_comb
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [PC_W-1:0]    pc_i,
  input  logic               bp_taken_i,
  output decoded_t           dec_o
);

  logic [6:0]          opcode;
  logic [FUNCT3_W-1:0] funct3;
  logic [6:0]          funct7;
  logic [PC_W-1:0]     imm_i;
  logic [PC_W-1:0]     imm_s;
  logic [PC_W-1:0]     imm_b;
  logic [PC_W-1:0]     imm_u;
  logic [PC_W-1:0]     imm_j;
  decoded_t            d;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Sign-extended immediates for every format
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                  instr_i[11:8], 1'b0};
  assign imm_u = {instr_i[31:12], 12'b0};
  assign imm_j = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                  instr_i[30:21], 1'b0};

  always_comb begin
    d          = '0;
    d.pc       = pc_i;
    d.bp_taken = bp_taken_i;
    d.rs1      = instr_i[19:15];
    d.rs2      = instr_i[24:20];
    d.rd       = instr_i[11:7];
    d.alu_op   = ALU_ADD;

    unique case (opcode)
      OPCODE_LUI: begin
        d.imm           = imm_u;
        d.alu_op        = ALU_PASS_B;
        d.alu_src_b_imm = 1'b1;
        d.rd_write      = 1'b1;
      end
      OPCODE_AUIPC: begin
        d.imm           = imm_u;
        d.alu_src_a_pc  = 1'b1;
        d.alu_src_b_imm = 1'b1;
        d.rd_write      = 1'b1;
      end
      OPCODE_JAL: begin
        d.imm           = imm_j;
        d.alu_src_a_pc  = 1'b1;
        d.alu_src_b_imm = 1'b1;
        d.jal           = 1'b1;
        d.rd_write      = 1'b1;
      end
      OPCODE_JALR: begin
        d.imm           = imm_i;
        d.alu_src_b_imm = 1'b1;
        d.jalr          = 1'b1;
        d.rd_write      = 1'b1;
        d.illegal       = (funct3 != 3'd0);
      end
      OPCODE_BRANCH: begin
        d.imm    = imm_b;
        d.branch = 1'b1;
        // EQ/NE compare via SUB, signed via SLT, unsigned via SLTU
        unique case (funct3[2:1])
          2'b00:   d.alu_op = ALU_SUB;
          2'b10:   d.alu_op = ALU_SLT;
          2'b11:   d.alu_op = ALU_SLTU;
          default: d.illegal = 1'b1;
        endcase
      end
      OPCODE_LOAD: begin
        d.imm           = imm_i;
        d.alu_src_b_imm = 1'b1;
        d.mem_read      = 1'b1;
        d.mem_funct3    = funct3;
        d.rd_write      = 1'b1;
        d.illegal       = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPCODE_STORE: begin
        d.imm           = imm_s;
        d.alu_src_b_imm = 1'b1;
        d.mem_write     = 1'b1;
        d.mem_funct3    = funct3;
        d.illegal       = (funct3 > 3'd2);
      end
      OPCODE_OP_IMM: begin
        d.imm           = imm_i;
        d.alu_src_b_imm = 1'b1;
        d.rd_write      = 1'b1;
        unique case (funct3)
          3'd0: d.alu_op = ALU_ADD;
          3'd1: begin
            d.alu_op  = ALU_SLL;
            d.illegal = (funct7 != FUNCT7_BASE);
          end
          3'd2: d.alu_op = ALU_SLT;
          3'd3: d.alu_op = ALU_SLTU;
          3'd4: d.alu_op = ALU_XOR;
          3'd5: begin
            // funct7 lives in the upper immediate bits for shifts
            if (funct7 == FUNCT7_BASE)     d.alu_op = ALU_SRL;
            else if (funct7 == FUNCT7_ALT) d.alu_op = ALU_SRA;
            else                           d.illegal = 1'b1;
          end
          3'd6: d.alu_op = ALU_OR;
          default: d.alu_op = ALU_AND;
        endcase
      end
      OPCODE_OP: begin
        d.rd_write = 1'b1;
        if (funct7 == FUNCT7_BASE) begin
          unique case (funct3)
            3'd0: d.alu_op = ALU_ADD;
            3'd1: d.alu_op = ALU_SLL;
            3'd2: d.alu_op = ALU_SLT;
            3'd3: d.alu_op = ALU_SLTU;
            3'd4: d.alu_op = ALU_XOR;
            3'd5: d.alu_op = ALU_SRL;
            3'd6: d.alu_op = ALU_OR;
            default: d.alu_op = ALU_AND;
          endcase
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'd0) begin
          d.alu_op = ALU_SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'd5) begin
          d.alu_op = ALU_SRA;
        end else begin
          d.illegal = 1'b1;
        end
      end
      OPCODE_MISC_MEM, OPCODE_SYSTEM: begin
        d.imm = imm_i;
      end
      default: d.illegal = 1'b1;
    endcase

    // Compressed/reserved encodings are not supported
    if (instr_i[1:0] != 2'b11) d.illegal = 1'b1;

    // Illegal instructions flow down the pipe with no side effects
    if (d.illegal) begin
      d.rd_write   = 1'b0;
      d.mem_read   = 1'b0;
      d.mem_write  = 1'b0;
      d.mem_funct3 = '0;
      d.branch     = 1'b0;
      d.jal        = 1'b0;
      d.jalr       = 1'b0;
    end
    if (d.rd == '0) d.rd_write = 1'b0;
  end

  assign dec_o = d;

endmodule

// File: rtl/decode.sv
// decode: RV32I decode pipeline stage with a one-entry skid buffer.
// Ports: clk, rst (sync, active-high), bus (decode_if.slave) carrying the
// fetch handshake, flush/stall controls and the registered decoded bundle.
module decode
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  decode_if.slave  bus
);

  if (XLEN != PC_W) begin : g_xlen_check
    $error("decode: only XLEN=32 is supported");
  end

  state_e   state_q;
  decoded_t out_q;
  decoded_t skid_q;
  logic     valid_q;
  logic     ready_q;
  decoded_t dec;
  logic     accept;

  decode_comb u_decode_comb (
    .instr_i    (bus.instr_in),
    .pc_i       (bus.pc_in),
    .bp_taken_i (bus.branch_predicted_taken_in),
    .dec_o      (dec)
  );

  assign accept = bus.valid_in && ready_q && !bus.flush_in;

  // Output/skid slot FSM; ready is a flop so fetch sees no combinational path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else if (bus.flush_in) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_q   <= dec;
            valid_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (!bus.stall_in) begin
            if (accept) begin
              out_q <= dec;
            end else begin
              valid_q <= 1'b0;
              state_q <= ST_EMPTY;
            end
          end else if (accept) begin
            skid_q  <= dec;
            ready_q <= 1'b0;
            state_q <= ST_SKID_FULL;
          end
        end
        ST_SKID_FULL: begin
          if (!bus.stall_in) begin
            out_q   <= skid_q;
            ready_q <= 1'b1;
            state_q <= ST_FULL;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.ready_out                  = ready_q;
  assign bus.valid_out                  = valid_q;
  assign bus.pc_out                     = out_q.pc;
  assign bus.rs1_addr_out               = out_q.rs1;
  assign bus.rs2_addr_out               = out_q.rs2;
  assign bus.rd_addr_out                = out_q.rd;
  assign bus.rd_write_out               = out_q.rd_write;
  assign bus.imm_out                    = out_q.imm;
  assign bus.alu_op_out                 = out_q.alu_op;
  assign bus.alu_src_a_pc_out           = out_q.alu_src_a_pc;
  assign bus.alu_src_b_imm_out          = out_q.alu_src_b_imm;
  assign bus.mem_read_out               = out_q.mem_read;
  assign bus.mem_write_out              = out_q.mem_write;
  assign bus.mem_funct3_out             = out_q.mem_funct3;
  assign bus.branch_out                 = out_q.branch;
  assign bus.jal_out                    = out_q.jal;
  assign bus.jalr_out                   = out_q.jalr;
  assign bus.branch_predicted_taken_out = out_q.bp_taken;
  assign bus.illegal_instr_out          = out_q.illegal;

endmodule

// File: tb/tb_decode.sv
// tb_decode: directed-vector bench for the decode stage.
module tb_decode;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  decode_if bus ();

  decode dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic bp);
    bus.valid_in                  = v;
    bus.instr_in                  = instr;
    bus.pc_in                     = pc;
    bus.branch_predicted_taken_in = bp;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    check("rst_valid", 32'(bus.valid_out), 32'd0);
    check("rst_ready", 32'(bus.ready_out), 32'd1);
    check("rst_pc", bus.pc_out, 32'h0);
    check("rst_imm", bus.imm_out, 32'h0);
    check("rst_rdw", 32'(bus.rd_write_out), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,5
    drive(1'b1, 32'h00500093, 32'h100, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("addi_valid", 32'(bus.valid_out), 32'd1);
    check("addi_pc", bus.pc_out, 32'h100);
    check("addi_rd", 32'(bus.rd_addr_out), 32'd1);
    check("addi_rs1", 32'(bus.rs1_addr_out), 32'd0);
    check("addi_imm", bus.imm_out, 32'd5);
    check("addi_alu", 32'(bus.alu_op_out), 32'd0);
    check("addi_srcb", 32'(bus.alu_src_b_imm_out), 32'd1);
    check("addi_rdw", 32'(bus.rd_write_out), 32'd1);
    tick();
    check("idle_valid", 32'(bus.valid_out), 32'd0);

    // BEQ x0,x0,-4 predicted taken
    drive(1'b1, 32'hFE000EE3, 32'h104, 1'b1);
    tick();
    check("beq_imm", bus.imm_out, 32'hFFFFFFFC);
    check("beq_branch", 32'(bus.branch_out), 32'd1);
    check("beq_alu", 32'(bus.alu_op_out), 32'd1);
    check("beq_rdw", 32'(bus.rd_write_out), 32'd0);
    check("beq_bp", 32'(bus.branch_predicted_taken_out), 32'd1);

    // LUI x1,0x12345 back-to-back
    drive(1'b1, 32'h123450B7, 32'h108, 1'b0);
    tick();
    check("lui_pc", bus.pc_out, 32'h108);
    check("lui_imm", bus.imm_out, 32'h12345000);
    check("lui_alu", 32'(bus.alu_op_out), 32'd10);
    check("lui_rdw", 32'(bus.rd_write_out), 32'd1);
    check("lui_bp", 32'(bus.branch_predicted_taken_out), 32'd0);

    // All-zero word is illegal
    drive(1'b1, 32'h00000000, 32'h10C, 1'b0);
    tick();
    check("ill0_valid", 32'(bus.valid_out), 32'd1);
    check("ill0_flag", 32'(bus.illegal_instr_out), 32'd1);
    check("ill0_rdw", 32'(bus.rd_write_out), 32'd0);

    // ADDI x0,x0,5: rd = x0 suppresses the write
    drive(1'b1, 32'h00500013, 32'h110, 1'b0);
    tick();
    check("x0_rdw", 32'(bus.rd_write_out), 32'd0);
    check("x0_ill", 32'(bus.illegal_instr_out), 32'd0);

    // OP funct7=0x20 with funct3=AND is illegal
    drive(1'b1, 32'h403170B3, 32'h114, 1'b0);
    tick();
    check("opalt_ill", 32'(bus.illegal_instr_out), 32'd1);
    check("opalt_rdw", 32'(bus.rd_write_out), 32'd0);

    // SUB x1,x2,x3 is legal
    drive(1'b1, 32'h403100B3, 32'h118, 1'b0);
    tick();
    check("sub_ill", 32'(bus.illegal_instr_out), 32'd0);
    check("sub_alu", 32'(bus.alu_op_out), 32'd1);
    check("sub_imm", bus.imm_out, 32'd0);

    // SW x2,8(x1)
    drive(1'b1, 32'h0020A423, 32'h11C, 1'b0);
    tick();
    check("sw_mw", 32'(bus.mem_write_out), 32'd1);
    check("sw_f3", 32'(bus.mem_funct3_out), 32'd2);
    check("sw_imm", bus.imm_out, 32'd8);
    check("sw_rdw", 32'(bus.rd_write_out), 32'd0);

    // JAL x1,8
    drive(1'b1, 32'h008000EF, 32'h120, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("jal_jal", 32'(bus.jal_out), 32'd1);
    check("jal_srca", 32'(bus.alu_src_a_pc_out), 32'd1);
    check("jal_imm", bus.imm_out, 32'd8);
    check("jal_rdw", 32'(bus.rd_write_out), 32'd1);
    tick();
    check("jal_drain", 32'(bus.valid_out), 32'd0);

    // Stall with A, B, C back to back
    bus.stall_in = 1'b1;
    drive(1'b1, 32'h00500093, 32'h200, 1'b0);
    tick();
    check("stA_pc", bus.pc_out, 32'h200);
    check("stA_ready", 32'(bus.ready_out), 32'd1);
    drive(1'b1, 32'h00500093, 32'h204, 1'b0);
    tick();
    check("stB_ready", 32'(bus.ready_out), 32'd0);
    check("stB_pc", bus.pc_out, 32'h200);
    drive(1'b1, 32'h00500093, 32'h208, 1'b0);
    tick();
    check("stC1_pc", bus.pc_out, 32'h200);
    check("stC1_ready", 32'(bus.ready_out), 32'd0);
    tick();
    check("stC2_pc", bus.pc_out, 32'h200);
    check("stC2_valid", 32'(bus.valid_out), 32'd1);
    bus.stall_in = 1'b0;
    tick();
    check("relB_pc", bus.pc_out, 32'h204);
    check("relB_ready", 32'(bus.ready_out), 32'd1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("relC_pc", bus.pc_out, 32'h208);
    check("relC_valid", 32'(bus.valid_out), 32'd1);
    tick();
    check("rel_drain", 32'(bus.valid_out), 32'd0);

    // Flush while in SKID_FULL
    bus.stall_in = 1'b1;
    drive(1'b1, 32'h00500093, 32'h300, 1'b0);
    tick();
    drive(1'b1, 32'h00500093, 32'h304, 1'b0);
    tick();
    check("fl_ready0", 32'(bus.ready_out), 32'd0);
    bus.flush_in = 1'b1;
    drive(1'b1, 32'h00500093, 32'h308, 1'b0);
    tick();
    bus.flush_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("fl_valid", 32'(bus.valid_out), 32'd0);
    check("fl_ready", 32'(bus.ready_out), 32'd1);
    bus.stall_in = 1'b0;
    tick();
    check("fl_gone1", 32'(bus.valid_out), 32'd0);
    tick();
    check("fl_gone2", 32'(bus.valid_out), 32'd0);
    drive(1'b1, 32'h00500093, 32'h30C, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    check("fl_next_pc", bus.pc_out, 32'h30C);
    check("fl_next_valid", 32'(bus.valid_out), 32'd1);

    // Reset (with flush) mid-stall in SKID_FULL
    bus.stall_in = 1'b1;
    drive(1'b1, 32'h123450B7, 32'h400, 1'b1);
    tick();
    drive(1'b1, 32'h123450B7, 32'h404, 1'b1);
    tick();
    check("rs_ready0", 32'(bus.ready_out), 32'd0);
    rst = 1'b1;
    bus.flush_in = 1'b1;
    tick();
    check("rs_valid", 32'(bus.valid_out), 32'd0);
    check("rs_ready", 32'(bus.ready_out), 32'd1);
    check("rs_pc", bus.pc_out, 32'h0);
    check("rs_imm", bus.imm_out, 32'h0);
    check("rs_rd", 32'(bus.rd_addr_out), 32'd0);
    check("rs_alu", 32'(bus.alu_op_out), 32'd0);
    check("rs_bp", 32'(bus.branch_predicted_taken_out), 32'd0);
    rst = 1'b0;
    bus.flush_in = 1'b0;
    bus.stall_in = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("rs_skid_gone", 32'(bus.valid_out), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Second pipeline stage of the core: takes the instruction word, PC and branch-prediction bit produced by `fetch`, and decodes it as RV32I into register addresses, a sign-extended immediate and control signals. The decoded bundle is registered for the execute stage. A one-entry skid buffer lets `ready_out` be driven purely from flops. The branch-mispredict flush that redirects `fetch` also clears this stage.

## Interface
Parameters:
- `XLEN`, 32, datapath and PC width; only 32 is supported.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, synchronous and active-high.
- `valid_in` in 1: the instruction/PC/prediction inputs are valid this cycle.
- `instr_in` in 32: instruction word from `fetch`.
- `pc_in` in 32: PC of `instr_in`.
- `branch_predicted_taken_in` in 1: prediction bit from `fetch`.
- `ready_out` out 1: the stage accepts an input this cycle.
- `flush_in` in 1: branch mispredicted; discard all held and incoming instructions.
- `stall_in` in 1: execute cannot consume the output this cycle.
- `valid_out` out 1: the output bundle is valid.
- `pc_out` out 32: PC of the output instruction.
- `rs1_addr_out`, `rs2_addr_out`, `rd_addr_out` out 5 each: register indices.
- `rd_write_out` out 1: write `rd`; forced to 0 when `rd` = x0 or the instruction is illegal.
- `imm_out` out 32: sign-extended I/S/B/U/J immediate; 0 for R-type.
- `alu_op_out` out 4: operation code from `decode_pkg::alu_op_e`.
- `alu_src_a_pc_out` out 1: ALU operand A is the PC (AUIPC/JAL), otherwise rs1.
- `alu_src_b_imm_out` out 1: ALU operand B is the immediate, otherwise rs2.
- `mem_read_out`, `mem_write_out` out 1 each: load or store.
- `mem_funct3_out` out 3: access width and sign extension, taken from funct3.
- `branch_out`, `jal_out`, `jalr_out` out 1 each: control-flow class.
- `branch_predicted_taken_out` out 1: prediction bit passed through.
- `illegal_instr_out` out 1: undecodable instruction.

## Operation
- Input accepted when `valid_in && ready_out && !flush_in`.
- Output consumed when `valid_out && !stall_in`.
- Decode is combinational from the input. Only decoded bundles are stored, in two slots:
  - OUT: the output register.
  - SKID: the one-entry skid buffer.
- States and transitions:
  - EMPTY: accept moves to FULL.
  - FULL, no stall: an accept keeps FULL with the new bundle; no accept moves to EMPTY.
  - FULL, stalled: an accept stores into SKID and moves to SKID_FULL; no accept holds.
  - SKID_FULL, no stall: SKID moves to OUT, then FULL.
  - SKID_FULL, stalled: hold.
- `ready_out` = (state != SKID_FULL); it is registered.
- Flush:
  - `flush_in` in any state moves to EMPTY at the next edge.
  - The input in that cycle is dropped; flush takes priority over accept and stall.
- Illegal conditions:
  - `instr_in[1:0]` != 2'b11.
  - Unknown opcode.
  - OP with funct7 not 0x00/0x20, or 0x20 with a funct3 other than ADD/SRL.
  - Shift-immediate with a bad funct7.
  - Load funct3 of 3, 6 or 7; store funct3 > 2; branch funct3 of 2 or 3; JALR funct3 != 0.
- An illegal instruction still advances: `valid_out` = 1, `illegal_instr_out` = 1, with `rd_write_out`, mem and control-flow outputs all 0.
- FENCE and SYSTEM decode as legal NOPs (`rd_write_out` = 0).
- LUI uses `alu_op` PASS_B.
- AUIPC, JAL and JALR use ADD. For JAL/JALR, execute writes `pc_out` + 4 to `rd`.
- Branches use SUB/SLT/SLTU according to funct3.

## Timing
- Latency: one cycle from accept to `valid_out`.
- Throughput: one instruction per cycle when not stalled.
- Stall behaviour:
  - The output bundle holds stable while `stall_in` is high.
  - At most one further input is accepted after the stall begins.
  - Order is preserved.
- Reset:
  - State EMPTY; `ready_out` = 1.
  - All other outputs 0, including the SKID contents.
  - Applies even mid-operation in SKID_FULL, effective at the next edge.
- Simultaneous `rst` and `flush_in`: `rst` wins; the result is identical.

## Structure
- `decode_pkg` holds:
  - RV32I opcode constants, shared with `fetch` in place of the `OPCODE_*` macros.
  - `alu_op_e` (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B).
  - `decoded_t`, the packed struct of all decoded outputs plus PC and prediction bit.
- Sub-module `decode_comb`:
  - Purely combinational, `instr_in` to `decoded_t`.
  - Contains immediate generation and illegal detection.
- The top module holds the OUT/SKID registers and the FSM.

## Test plan
- ADDI x1,x0,5 (0x00500093) at pc 0x100 -> next cycle:
  - `valid_out` = 1, `pc_out` = 0x100.
  - `rd` = 1, `rs1` = 0, `imm` = 5, ADD, `alu_src_b_imm` = 1, `rd_write` = 1.
- BEQ x0,x0,-4 (0xFE000EE3) with prediction = 1 -> `imm` = 0xFFFFFFFC, `branch_out` = 1, SUB, `rd_write` = 0, `branch_predicted_taken_out` = 1.
- LUI x1,0x12345 (0x123450B7) -> `imm` = 0x12345000, PASS_B, `rd_write` = 1.
- `stall_in` high with three back-to-back valid inputs A, B, C:
  - After B is accepted, `ready_out` = 0 and C is held.
  - `valid_out` shows A throughout the stall.
  - Releasing the stall yields A, B, C in order with no loss or duplication.
- In SKID_FULL, pulse `flush_in` with `valid_in` = 1 -> next cycle `valid_out` = 0, `ready_out` = 1; the flushed input never appears.
- 0x00000000 -> `valid_out` = 1, `illegal_instr_out` = 1, `rd_write` = 0.
- Assert `rst` mid-stall -> all outputs 0 and `ready_out` = 1 after one edge.
